pma_tx_serializer: RTL and testbench
====================================

PMA_TX_SERIALIZER -- requirements
Module: pma_tx_serializer

Interface
REQ-001 The block SHALL have exactly one clock and one reset. Reset SHALL be asynchronous and active-low.
REQ-002 GTX_CLK  input  1  transmit clock; all state SHALL update on its rising edge.
REQ-003 mr_main_reset  input  1  asynchronous active-low reset; 0 SHALL force the reset state immediately.
REQ-004 PUDR  input  10  code-group from the PCS transmit code-group stage; bit 9 = 'a', bit 0 = 'j'.
REQ-005 pudr_valid  input  1  PUDR holds a code-group to accept.
REQ-006 pudr_ready  output  1  block can accept a code-group this cycle.
REQ-007 tx_bit  output  1  serial line bit, registered.
REQ-008 tx_active  output  1  tx_bit carries a code-group bit this cycle.
REQ-009 underrun_cnt  output  8  saturating count of starvation events.
REQ-010 comma_sent  output  1  one-cycle pulse on the last bit of a comma code-group (see Configuration).

Function
REQ-011 A code-group SHALL be accepted at a rising edge where pudr_valid=1 and pudr_ready=1.
REQ-012 Accepted code-groups SHALL enter a 2-entry FIFO, in order; pudr_ready SHALL be 1 exactly when FIFO occupancy is less than 2.
REQ-013 When occupancy is 1, a write and a pop in the same cycle SHALL both take effect, leaving occupancy at 1.
REQ-014 The FSM SHALL have states IDLE and SHIFT, plus a 4-bit bit index 0..9.
REQ-015 IDLE with FIFO non-empty: at the next edge, pop the head into a 10-bit shift register, drive tx_bit=head[9], set index=0, and enter SHIFT.
REQ-016 SHIFT with index<9: at each edge, increment index and drive the next bit. Bits SHALL be sent MSB first: PUDR[9], PUDR[8], ... PUDR[0].
REQ-017 SHIFT with index=9 and FIFO non-empty: at the next edge, pop and load the next code-group with index=0, so there is no gap between code-groups.
REQ-018 SHIFT with index=9 and FIFO empty: at the next edge, go to IDLE and increment underrun_cnt, which SHALL saturate at 255.
REQ-019 In IDLE, tx_bit SHALL be 0 and tx_active SHALL be 0. In SHIFT, tx_active SHALL be 1.
REQ-020 Latency: a code-group written at edge N into an empty FIFO while in IDLE SHALL put its bit 9 on tx_bit after edge N+1, and its bit 0 after edge N+10.
REQ-021 A code-group written into an empty FIFO on the same edge that index=9 completes SHALL NOT be popped on that edge. The FSM SHALL go to IDLE, count one underrun, and load that code-group at the following edge.
REQ-022 A code-group in progress SHALL NOT be altered by any FIFO write.

Reset
REQ-023 While mr_main_reset=0, the outputs SHALL be: FSM=IDLE, index=0, FIFO empty, tx_bit=0, tx_active=0, underrun_cnt=0, comma_sent=0, pudr_ready=0.
REQ-024 After reset is released, pudr_ready SHALL become 1 from the first rising edge.
REQ-025 Reset asserted mid-code-group SHALL discard the partial code-group and all FIFO contents. No bits of them SHALL be sent after release.

Configuration
REQ-026 Macro PMA_TX_COMMA_DETECT_EN SHALL control comma detection.
REQ-027 With the macro defined: when a code-group is loaded, the block SHALL record whether its bits [9:3] equal 0011111 or 1100000. comma_sent SHALL pulse for one cycle while that code-group's index=9 (its last bit) is on tx_bit.
REQ-028 Without the macro: comma_sent SHALL be tied to 0 and no comparison logic SHALL be built. All other behaviour SHALL be identical.

Verification
REQ-029 Reset release, then PUDR=0011111010 with valid for one cycle -> tx_bit sequence 0,0,1,1,1,1,1,0,1,0; tx_active=1 for exactly 10 cycles; underrun_cnt=1; comma_sent pulses at the 10th bit (with macro), stays 0 (without macro).
REQ-030 Back-to-back stream of 0011111010 then 1001000101 with valid held high -> 20 contiguous active bits; pudr_ready drops when occupancy reaches 2; underrun_cnt=1 after the stream drains.
REQ-031 Hold valid=0 for 300 gaps between single code-groups -> underrun_cnt saturates at 255, no wrap.
REQ-032 Assert mr_main_reset=0 at bit index 4 of 1100000101 with 1 FIFO entry pending -> tx_bit=0 and tx_active=0 immediately; after release, no further bits of either code-group appear.
REQ-033 FIFO at occupancy 1, write on the same edge as a pop -> no data loss; order preserved; occupancy stays 1.

Source files
------------

// File: rtl/pma_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// pma_tx_serializer_if
// Code-group handshake between the PCS transmit code-group stage and the
// PMA serializer.
//   PUDR        10-bit code-group, bit 9 = 'a' (sent first), bit 0 = 'j'
//   pudr_valid  PUDR holds a code-group to accept
//   pudr_ready  serializer can accept a code-group this cycle
// A code-group transfers on a rising edge where pudr_valid and pudr_ready
// are both 1.
// ---------------------------------------------------------------------------
interface pma_tx_serializer_if;
    logic [9:0] PUDR;
    logic       pudr_valid;
    logic       pudr_ready;

    modport master (
        output PUDR,
        output pudr_valid,
        input  pudr_ready
    );

    modport slave (
        input  PUDR,
        input  pudr_valid,
        output pudr_ready
    );
endinterface

// File: rtl/pma_tx_serializer.sv
// ---------------------------------------------------------------------------
// pma_tx_serializer
// Accepts 10-bit code-groups into a 2-entry FIFO and shifts them out MSB
// first on tx_bit, one bit per GTX_CLK, with no gap between queued groups.
//
// Ports
//   GTX_CLK        transmit clock, all state updates on its rising edge
//   mr_main_reset  asynchronous active-low reset
//   pudr           code-group handshake (slave side of pma_tx_serializer_if)
//   tx_bit         registered serial line bit
//   tx_active      tx_bit carries a code-group bit this cycle
//   underrun_cnt   saturating count of starvation events (line went idle
//                  after a code-group because the FIFO was empty)
//   comma_sent     one-cycle pulse while the last bit of a comma code-group
//                  is on tx_bit
//
// Build option
//   PMA_TX_COMMA_DETECT_EN  when defined, comma detection is built and
//                           drives comma_sent; otherwise comma_sent is 0.
//
// States
//   IDLE  | line idle, tx_bit=0; loads the FIFO head as soon as one exists
//   SHIFT | sending bit idx (0..9) of the current code-group
// ---------------------------------------------------------------------------
module pma_tx_serializer (
    input  logic                      GTX_CLK,
    input  logic                      mr_main_reset,
    pma_tx_serializer_if.slave        pudr,
    output logic                      tx_bit,
    output logic                      tx_active,
    output logic [7:0]                underrun_cnt,
    output logic                      comma_sent
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic       load;
    logic       underrun;

    logic [1:0] occ;
    logic [9:0] q0;
    logic [9:0] q1;
    logic       wr;
    logic       ready_en;

    // Bits [8:0] of the code-group in flight; bit 9 goes straight from the
    // FIFO head to tx_bit at load time.
    logic [8:0] sr;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state <= IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Pop decisions use the registered occupancy, so a group written on the
    // same edge that the last bit completes is not visible yet: the FSM
    // drops to IDLE for one cycle and loads it on the following edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        underrun  = 1'b0;
        case (state)
            IDLE: begin
                if (occ != 2'd0) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                    idx_nxt   = 4'd0;
                end
            end
            SHIFT: begin
                if (idx != 4'd9) begin
                    idx_nxt = idx + 4'd1;
                end else if (occ != 2'd0) begin
                    load    = 1'b1;
                    idx_nxt = 4'd0;
                end else begin
                    state_nxt = IDLE;
                    idx_nxt   = 4'd0;
                    underrun  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 4'd0;
            end
        endcase
    end

    assign tx_active = (state == SHIFT);

    // -----------------------------------------------------------------------
    // 2-entry FIFO, q0 is the head
    // -----------------------------------------------------------------------
    // ready_en holds pudr_ready low while in reset and releases it on the
    // first edge afterwards.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign pudr.pudr_ready = ready_en && (occ != 2'd2);
    assign wr              = pudr.pudr_valid && pudr.pudr_ready;

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            occ <= 2'd0;
            q0  <= 10'd0;
            q1  <= 10'd0;
        end else begin
            case ({wr, load})
                2'b10: begin
                    if (occ == 2'd0) begin
                        q0 <= pudr.PUDR;
                    end else begin
                        q1 <= pudr.PUDR;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    q0  <= q1;
                    occ <= occ - 2'd1;
                end
                // Write and pop together: a write needs occ<2 and a pop needs
                // occ>0, so occ is 1 and the new group simply replaces the head.
                2'b11: begin
                    q0 <= pudr.PUDR;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Shifter and line output
    // -----------------------------------------------------------------------
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            sr     <= 9'd0;
            tx_bit <= 1'b0;
        end else if (load) begin
            sr     <= q0[8:0];
            tx_bit <= q0[9];
        end else if (state_nxt == SHIFT) begin
            sr     <= {sr[7:0], 1'b0};
            tx_bit <= sr[8];
        end else begin
            tx_bit <= 1'b0;
        end
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            underrun_cnt <= 8'd0;
        end else if (underrun && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Comma detection
    // -----------------------------------------------------------------------
`ifdef PMA_TX_COMMA_DETECT_EN
    logic comma_flag;

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            comma_flag <= 1'b0;
        end else if (load) begin
            comma_flag <= (q0[9:3] == 7'b0011111) || (q0[9:3] == 7'b1100000);
        end
    end

    assign comma_sent = comma_flag && (state == SHIFT) && (idx == 4'd9);
`else
    assign comma_sent = 1'b0;
`endif

endmodule

// File: tb/tb_pma_tx_serializer.sv
module tb_pma_tx_serializer;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic       tx_bit;
    logic       tx_active;
    logic [7:0] underrun_cnt;
    logic       comma_sent;

    pma_tx_serializer_if pif ();

    pma_tx_serializer dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .pudr          (pif),
        .tx_bit        (tx_bit),
        .tx_active     (tx_active),
        .underrun_cnt  (underrun_cnt),
        .comma_sent    (comma_sent)
    );

    always #5 GTX_CLK = ~GTX_CLK;

`ifdef PMA_TX_COMMA_DETECT_EN
    localparam bit COMMA_EN = 1'b1;
`else
    localparam bit COMMA_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO as a queue, the group on the line plus its bit
    // position, and a counter of idle transitions.
    logic [9:0] m_fifo[$];
    logic [9:0] m_cur;
    int         m_pos;
    bit         m_busy;
    int         m_under;
    bit         m_rdy_en;

    logic       obs[$];
    int         comma_seen;
    bit         ready_low_seen;

    typedef struct {
        logic [9:0] cg;
        bit         comma;
    } vec_t;

    vec_t vecs[8];

    function automatic bit is_comma(logic [9:0] cg);
        return (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    endfunction

    function automatic bit model_ready();
        return m_rdy_en && (m_fifo.size() < 2);
    endfunction

    function automatic logic [9:0] obs_word(int k);
        logic [9:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            if (10 * k + i < obs.size()) w[9-i] = obs[10*k+i];
        end
        return w;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cur    = '0;
        m_pos    = 0;
        m_busy   = 1'b0;
        m_under  = 0;
        m_rdy_en = 1'b0;
    endtask

    task automatic model_edge(bit valid, logic [9:0] data);
        bit acc;
        acc = valid && model_ready();
        if (!m_busy) begin
            if (m_fifo.size() > 0) begin
                m_cur  = m_fifo.pop_front();
                m_pos  = 0;
                m_busy = 1'b1;
            end
        end else if (m_pos < 9) begin
            m_pos++;
        end else if (m_fifo.size() > 0) begin
            m_cur = m_fifo.pop_front();
            m_pos = 0;
        end else begin
            m_busy = 1'b0;
            if (m_under < 255) m_under++;
        end
        if (acc) m_fifo.push_back(data);
        m_rdy_en = 1'b1;
    endtask

    task automatic check_outputs();
        chk("tx_bit", tx_bit, m_busy ? m_cur[9-m_pos] : 1'b0);
        chk("tx_active", tx_active, m_busy);
        chk("pudr_ready", pif.pudr_ready, model_ready());
        chk("underrun_cnt", underrun_cnt, m_under);
        chk("comma_sent", comma_sent, COMMA_EN && m_busy && (m_pos == 9) && is_comma(m_cur));
    endtask

    task automatic cycle(bit valid, logic [9:0] data);
        pif.pudr_valid = valid;
        pif.PUDR       = data;
        @(posedge GTX_CLK);
        if (mr_main_reset) model_edge(valid, data);
        else model_reset();
        @(negedge GTX_CLK);
        check_outputs();
        if (tx_active === 1'b1) obs.push_back(tx_bit);
        if (comma_sent === 1'b1) comma_seen++;
        if (pif.pudr_ready === 1'b0 && mr_main_reset) ready_low_seen = 1'b1;
    endtask

    task automatic do_reset();
        mr_main_reset = 1'b0;
        #1;
        model_reset();
        chk("rst_tx_bit", tx_bit, 1'b0);
        chk("rst_tx_active", tx_active, 1'b0);
        chk("rst_ready", pif.pudr_ready, 1'b0);
        chk("rst_underrun", underrun_cnt, 8'd0);
        chk("rst_comma", comma_sent, 1'b0);
        cycle(1'b0, '0);
        cycle(1'b1, 10'h3FF);
        mr_main_reset = 1'b1;
    endtask

    task automatic send_one(logic [9:0] cg);
        cycle(1'b1, cg);
        for (int i = 0; i < 11; i++) cycle(1'b0, '0);
    endtask

    task automatic push_hs(logic [9:0] cg);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = model_ready();
            cycle(1'b1, cg);
        end
        chk("handshake_accepted", acc, 1'b1);
    endtask

    initial begin
        logic [9:0] cg_a, cg_b, cg_c, cg_x;
        int         u0;

        vecs[0] = '{10'b0011111010, 1'b1};
        vecs[1] = '{10'b1100000101, 1'b1};
        vecs[2] = '{10'b1001000101, 1'b0};
        vecs[3] = '{10'b0011111001, 1'b1};
        vecs[4] = '{10'b1100000110, 1'b1};
        vecs[5] = '{10'b0101010101, 1'b0};
        vecs[6] = '{10'b0011110000, 1'b0};
        vecs[7] = '{10'b1100001000, 1'b0};

        pif.pudr_valid = 1'b0;
        pif.PUDR       = '0;
        mr_main_reset  = 1'b1;
        model_reset();
        comma_seen     = 0;
        ready_low_seen = 1'b0;
        #2;
        do_reset();

        // First edge after release raises ready.
        cycle(1'b0, '0);
        chk("ready_after_release", pif.pudr_ready, 1'b1);

        // Single comma code-group from idle.
        obs.delete();
        comma_seen = 0;
        send_one(10'b0011111010);
        chk("single_len", obs.size(), 10);
        chk("single_bits", obs_word(0), 10'b0011111010);
        chk("single_underrun", underrun_cnt, 8'd1);
        chk("single_comma", comma_seen, COMMA_EN ? 1 : 0);

        // Vector table: each group alone, serial image and comma pulses.
        foreach (vecs[k]) begin
            obs.delete();
            comma_seen = 0;
            send_one(vecs[k].cg);
            chk("vec_len", obs.size(), 10);
            chk("vec_bits", obs_word(0), vecs[k].cg);
            chk("vec_comma", comma_seen, (COMMA_EN && vecs[k].comma) ? 1 : 0);
        end

        // Back-to-back pair; second write coincides with the pop of the first.
        cg_a = 10'b0011111010;
        cg_b = 10'b1001000101;
        obs.delete();
        u0 = m_under;
        cycle(1'b1, cg_a);
        cycle(1'b1, cg_b);
        chk("pop_write_ready", pif.pudr_ready, 1'b1);
        for (int i = 0; i < 22; i++) cycle(1'b0, '0);
        chk("b2b_len", obs.size(), 20);
        chk("b2b_first", obs_word(0), cg_a);
        chk("b2b_second", obs_word(1), cg_b);
        chk("b2b_underrun", underrun_cnt, u0 + 1);

        // Three-group stream fills the FIFO, ready must drop.
        cg_c = 10'b0110101100;
        obs.delete();
        ready_low_seen = 1'b0;
        u0 = m_under;
        push_hs(cg_a);
        push_hs(cg_b);
        push_hs(cg_c);
        for (int i = 0; i < 35; i++) cycle(1'b0, '0);
        chk("full_ready_dropped", ready_low_seen, 1'b1);
        chk("stream3_len", obs.size(), 30);
        chk("stream3_w0", obs_word(0), cg_a);
        chk("stream3_w1", obs_word(1), cg_b);
        chk("stream3_w2", obs_word(2), cg_c);
        chk("stream3_underrun", underrun_cnt, u0 + 1);

        // Reset at bit index 4 with one group pending.
        cg_c = 10'b1100000101;
        cg_x = 10'b0101100111;
        cycle(1'b1, cg_c);
        cycle(1'b1, cg_x);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0);
        chk("pre_reset_bit4", tx_bit, cg_c[5]);
        do_reset();
        obs.delete();
        for (int i = 0; i < 15; i++) cycle(1'b0, '0);
        chk("post_reset_no_bits", obs.size(), 0);
        chk("post_reset_underrun", underrun_cnt, 8'd0);

        // Randomized traffic with bursty valid density.
        for (int blk = 0; blk < 15; blk++) begin
            int dens;
            dens = $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                logic [9:0] d;
                bit         v;
                v = ($urandom_range(0, 4) < dens);
                d = 10'($urandom);
                if ($urandom_range(0, 3) == 0)
                    d[9:3] = $urandom_range(0, 1) ? 7'b0011111 : 7'b1100000;
                cycle(v, d);
            end
        end

        // Underrun saturation.
        do_reset();
        for (int i = 0; i < 300; i++) send_one(10'($urandom));
        chk("underrun_saturated", underrun_cnt, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
